// File: rtl/dcache_port_arbiter_if.sv
// Bundle of the load/store request, D-cache request/response and completion
// signals shared between the LSU-side environment and dcache_port_arbiter.
interface dcache_port_arbiter_if #(
    parameter int LDQ_ENTRIES     = 8,
    parameter int SDQ_ENTRIES     = 8,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int LDQ_IDX_W = $clog2(LDQ_ENTRIES);
    localparam int SDQ_IDX_W = $clog2(SDQ_ENTRIES);
    localparam int TAG_W     = $clog2(MAX_OUTSTANDING);

    logic                 ld_req_vld;
    logic [LDQ_IDX_W-1:0] ld_req_ldq_idx;
    logic [31:0]          ld_req_addr;
    logic                 ld_req_rdy;
    logic                 st_req_vld;
    logic [SDQ_IDX_W-1:0] st_req_sdq_idx;
    logic [31:0]          st_req_addr;
    logic [31:0]          st_req_wdata;
    logic [3:0]           st_req_be;
    logic                 st_req_rdy;
    logic                 sdq_almost_full;
    logic                 flush;
    logic                 dc_req_vld;
    logic                 dc_req_we;
    logic [31:0]          dc_req_addr;
    logic [31:0]          dc_req_wdata;
    logic [3:0]           dc_req_be;
    logic [TAG_W-1:0]     dc_req_tag;
    logic                 dc_req_rdy;
    logic                 dc_rsp_vld;
    logic [TAG_W-1:0]     dc_rsp_tag;
    logic                 ld_done_vld;
    logic [LDQ_IDX_W-1:0] ld_done_ldq_idx;
    logic                 st_done_vld;
    logic [SDQ_IDX_W-1:0] st_done_sdq_idx;

    // Environment side: LDQ/SDQ issue logic plus the D-cache itself.
    modport master (
        output ld_req_vld, ld_req_ldq_idx, ld_req_addr,
        output st_req_vld, st_req_sdq_idx, st_req_addr, st_req_wdata, st_req_be,
        output sdq_almost_full, flush, dc_req_rdy, dc_rsp_vld, dc_rsp_tag,
        input  ld_req_rdy, st_req_rdy,
        input  dc_req_vld, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_be, dc_req_tag,
        input  ld_done_vld, ld_done_ldq_idx, st_done_vld, st_done_sdq_idx
    );

    // Arbiter side.
    modport slave (
        input  ld_req_vld, ld_req_ldq_idx, ld_req_addr,
        input  st_req_vld, st_req_sdq_idx, st_req_addr, st_req_wdata, st_req_be,
        input  sdq_almost_full, flush, dc_req_rdy, dc_rsp_vld, dc_rsp_tag,
        output ld_req_rdy, st_req_rdy,
        output dc_req_vld, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_be, dc_req_tag,
        output ld_done_vld, ld_done_ldq_idx, st_done_vld, st_done_sdq_idx
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache request port between load issue and store drain.
// Each granted op is tagged with the lowest free in-flight slot; responses are
// routed back by tag as load-complete or store-done. Loads alive at a flush are
// marked killed and complete silently.
module dcache_port_arbiter #(
    parameter int LDQ_ENTRIES     = 8,
    parameter int SDQ_ENTRIES     = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcache_port_arbiter_if.slave bus
);
    localparam int LDQ_IDX_W = $clog2(LDQ_ENTRIES);
    localparam int SDQ_IDX_W = $clog2(SDQ_ENTRIES);
    localparam int TAG_W     = $clog2(MAX_OUTSTANDING);
    localparam int IDX_W     = (LDQ_IDX_W > SDQ_IDX_W) ? LDQ_IDX_W : SDQ_IDX_W;
    localparam int CNT_W     = $clog2(STARVE_LIMIT + 1);

    // In-flight tag table
    logic [MAX_OUTSTANDING-1:0] busy_r;
    logic [MAX_OUTSTANDING-1:0] we_r;
    logic [MAX_OUTSTANDING-1:0] killed_r;
    logic [IDX_W-1:0]           idx_r [MAX_OUTSTANDING];

    logic [CNT_W-1:0] starve_cnt_r;

    // Output request register
    logic             dc_req_vld_r;
    logic             dc_req_we_r;
    logic [31:0]      dc_req_addr_r;
    logic [31:0]      dc_req_wdata_r;
    logic [3:0]       dc_req_be_r;
    logic [TAG_W-1:0] dc_req_tag_r;

    logic                 ld_done_vld_r;
    logic [LDQ_IDX_W-1:0] ld_done_idx_r;
    logic                 st_done_vld_r;
    logic [SDQ_IDX_W-1:0] st_done_idx_r;

    logic             can_take_s;
    logic             store_first_s;
    logic             grant_ld_s;
    logic             grant_st_s;
    logic [TAG_W-1:0] alloc_tag_s;
    logic             rsp_hit_s;
    logic             rsp_we_s;
    logic             rsp_killed_s;
    logic [IDX_W-1:0] rsp_idx_s;

    // Lowest-numbered idle slot; only meaningful when at least one is idle.
    function automatic logic [TAG_W-1:0] lowest_free(input logic [MAX_OUTSTANDING-1:0] busy);
        logic [TAG_W-1:0] slot;
        slot = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                slot = TAG_W'(i);
            end
        end
        return slot;
    endfunction

    // Arbitration, tag allocation and response lookup. Allocation looks at the
    // table before this cycle's response frees a slot.
    always_comb begin
        can_take_s    = (!dc_req_vld_r || bus.dc_req_rdy) && !(&busy_r);
        store_first_s = bus.sdq_almost_full || (starve_cnt_r == CNT_W'(STARVE_LIMIT));
        grant_st_s    = 1'b0;
        grant_ld_s    = 1'b0;
        if (can_take_s && bus.st_req_vld && (store_first_s || !bus.ld_req_vld)) begin
            grant_st_s = 1'b1;
        end else if (can_take_s && bus.ld_req_vld) begin
            grant_ld_s = 1'b1;
        end else begin
            grant_st_s = 1'b0;
            grant_ld_s = 1'b0;
        end
        alloc_tag_s  = lowest_free(busy_r);
        rsp_hit_s    = bus.dc_rsp_vld && busy_r[bus.dc_rsp_tag];
        rsp_we_s     = we_r[bus.dc_rsp_tag];
        rsp_killed_s = killed_r[bus.dc_rsp_tag];
        rsp_idx_s    = idx_r[bus.dc_rsp_tag];
    end

    assign bus.ld_req_rdy      = grant_ld_s;
    assign bus.st_req_rdy      = grant_st_s;
    assign bus.dc_req_vld      = dc_req_vld_r;
    assign bus.dc_req_we       = dc_req_we_r;
    assign bus.dc_req_addr     = dc_req_addr_r;
    assign bus.dc_req_wdata    = dc_req_wdata_r;
    assign bus.dc_req_be       = dc_req_be_r;
    assign bus.dc_req_tag      = dc_req_tag_r;
    assign bus.ld_done_vld     = ld_done_vld_r;
    assign bus.ld_done_ldq_idx = ld_done_idx_r;
    assign bus.st_done_vld     = st_done_vld_r;
    assign bus.st_done_sdq_idx = st_done_idx_r;

    // Output register: load on grant, hold until the D-cache accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_req_vld_r   <= 1'b0;
            dc_req_we_r    <= 1'b0;
            dc_req_addr_r  <= 32'h0;
            dc_req_wdata_r <= 32'h0;
            dc_req_be_r    <= 4'h0;
            dc_req_tag_r   <= '0;
        end else if (grant_st_s) begin
            dc_req_vld_r   <= 1'b1;
            dc_req_we_r    <= 1'b1;
            dc_req_addr_r  <= bus.st_req_addr;
            dc_req_wdata_r <= bus.st_req_wdata;
            dc_req_be_r    <= bus.st_req_be;
            dc_req_tag_r   <= alloc_tag_s;
        end else if (grant_ld_s) begin
            dc_req_vld_r   <= 1'b1;
            dc_req_we_r    <= 1'b0;
            dc_req_addr_r  <= bus.ld_req_addr;
            dc_req_wdata_r <= 32'h0;
            dc_req_be_r    <= 4'hF;
            dc_req_tag_r   <= alloc_tag_s;
        end else if (bus.dc_req_rdy) begin
            dc_req_vld_r <= 1'b0;
        end
    end

    // Tag table: free on response, fill on grant, mark busy loads killed on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= '0;
            we_r     <= '0;
            killed_r <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                idx_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (rsp_hit_s && (bus.dc_rsp_tag == TAG_W'(i))) begin
                    busy_r[i] <= 1'b0;
                end else if ((grant_st_s || grant_ld_s) && (alloc_tag_s == TAG_W'(i))) begin
                    busy_r[i]   <= 1'b1;
                    we_r[i]     <= grant_st_s;
                    killed_r[i] <= grant_ld_s && bus.flush;
                    idx_r[i]    <= grant_st_s ? IDX_W'(bus.st_req_sdq_idx) : IDX_W'(bus.ld_req_ldq_idx);
                end else if (bus.flush && busy_r[i] && !we_r[i]) begin
                    killed_r[i] <= 1'b1;
                end
            end
        end
    end

    // Completion pulses, one cycle after the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_done_vld_r <= 1'b0;
            ld_done_idx_r <= '0;
            st_done_vld_r <= 1'b0;
            st_done_idx_r <= '0;
        end else begin
            ld_done_vld_r <= rsp_hit_s && !rsp_we_s && !rsp_killed_s;
            ld_done_idx_r <= rsp_idx_s[LDQ_IDX_W-1:0];
            st_done_vld_r <= rsp_hit_s && rsp_we_s;
            st_done_idx_r <= rsp_idx_s[SDQ_IDX_W-1:0];
        end
    end

    // Store starvation counter: counts load grants that bypassed a waiting store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= '0;
        end else if (grant_st_s || !bus.st_req_vld) begin
            starve_cnt_r <= '0;
        end else if (grant_ld_s && (starve_cnt_r != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with request and completion scoreboards.
module tb_dcache_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  tag;
    } req_t;

    typedef struct {
        logic       is_st;
        logic [2:0] idx;
    } done_t;

    req_t  exp_req_q [$];
    done_t exp_done_q [$];

    dcache_port_arbiter_if #(.LDQ_ENTRIES(8), .SDQ_ENTRIES(8), .MAX_OUTSTANDING(4)) bus ();

    dcache_port_arbiter #(
        .LDQ_ENTRIES(8), .SDQ_ENTRIES(8), .MAX_OUTSTANDING(4), .STARVE_LIMIT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_ld(input logic vld, input logic [2:0] idx, input logic [31:0] addr);
        bus.ld_req_vld     = vld;
        bus.ld_req_ldq_idx = idx;
        bus.ld_req_addr    = addr;
    endtask

    task automatic set_st(input logic vld, input logic [2:0] idx, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        bus.st_req_vld     = vld;
        bus.st_req_sdq_idx = idx;
        bus.st_req_addr    = addr;
        bus.st_req_wdata   = wdata;
        bus.st_req_be      = be;
    endtask

    task automatic set_rsp(input logic vld, input logic [1:0] tag);
        bus.dc_rsp_vld = vld;
        bus.dc_rsp_tag = tag;
    endtask

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [1:0] tag);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.be = be; r.tag = tag;
        exp_req_q.push_back(r);
    endtask

    task automatic push_done(input logic is_st, input logic [2:0] idx);
        done_t d;
        d.is_st = is_st; d.idx = idx;
        exp_done_q.push_back(d);
    endtask

    task automatic check_req(input string name);
        req_t e;
        n_tests++;
        assert (exp_req_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s observed=request expected=empty scoreboard", name);
            return;
        end
        e = exp_req_q.pop_front();
        chk({name, "_vld"},   bus.dc_req_vld,   32'd1);
        chk({name, "_we"},    bus.dc_req_we,    32'(e.we));
        chk({name, "_addr"},  bus.dc_req_addr,  e.addr);
        chk({name, "_wdata"}, bus.dc_req_wdata, e.wdata);
        chk({name, "_be"},    bus.dc_req_be,    32'(e.be));
        chk({name, "_tag"},   bus.dc_req_tag,   32'(e.tag));
    endtask

    task automatic check_done(input string name);
        done_t e;
        n_tests++;
        assert (exp_done_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s observed=done expected=empty scoreboard", name);
            return;
        end
        e = exp_done_q.pop_front();
        if (e.is_st) begin
            chk({name, "_st_vld"}, bus.st_done_vld,     32'd1);
            chk({name, "_st_idx"}, bus.st_done_sdq_idx, 32'(e.idx));
            chk({name, "_ld_vld"}, bus.ld_done_vld,     32'd0);
        end else begin
            chk({name, "_ld_vld"}, bus.ld_done_vld,     32'd1);
            chk({name, "_ld_idx"}, bus.ld_done_ldq_idx, 32'(e.idx));
            chk({name, "_st_vld"}, bus.st_done_vld,     32'd0);
        end
    endtask

    task automatic check_no_done(input string name);
        chk({name, "_ld_vld"}, bus.ld_done_vld, 32'd0);
        chk({name, "_st_vld"}, bus.st_done_vld, 32'd0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rtag [4];
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set_ld(1'b0, 3'd0, 32'h0);
        set_st(1'b0, 3'd0, 32'h0, 32'h0, 4'h0);
        set_rsp(1'b0, 2'd0);
        bus.sdq_almost_full = 1'b0;
        bus.flush           = 1'b0;
        bus.dc_req_rdy      = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dc_vld", bus.dc_req_vld, 32'd0);
        check_no_done("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single load, response, one-cycle completion pulse
        @(negedge clk);
        set_ld(1'b1, 3'd3, 32'h100);
        #1;
        chk("ld1_ld_rdy", bus.ld_req_rdy, 32'd1);
        chk("ld1_st_rdy", bus.st_req_rdy, 32'd0);
        push_req(1'b0, 32'h100, 32'h0, 4'hF, 2'd0);
        tick();
        check_req("ld1_req");
        @(negedge clk);
        set_ld(1'b0, 3'd0, 32'h0);
        tick();
        chk("ld1_vld_clear", bus.dc_req_vld, 32'd0);
        @(negedge clk);
        set_rsp(1'b1, 2'd0);
        push_done(1'b0, 3'd3);
        tick();
        check_done("ld1_done");
        @(negedge clk);
        set_rsp(1'b0, 2'd0);
        tick();
        check_no_done("ld1_pulse_end");

        // Both always valid: L,L,L,L,S repeating; tags alternate 0,1
        for (int i = 0; i < 10; i++) begin
            logic exp_st;
            @(negedge clk);
            exp_st = ((i % 5) == 4);
            set_ld(1'b1, 3'(i), 32'h2000 + 32'(i * 4));
            set_st(1'b1, 3'(i), 32'h3000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'h3);
            set_rsp(bus.dc_req_vld, bus.dc_req_tag);
            #1;
            chk("pat_ld_rdy", bus.ld_req_rdy, 32'(!exp_st));
            chk("pat_st_rdy", bus.st_req_rdy, 32'(exp_st));
            if (exp_st) begin
                push_req(1'b1, 32'h3000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'h3, 2'(i % 2));
            end else begin
                push_req(1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'hF, 2'(i % 2));
            end
            tick();
            check_req("pat_req");
        end
        @(negedge clk);
        set_ld(1'b0, 3'd0, 32'h0);
        set_st(1'b0, 3'd0, 32'h0, 32'h0, 4'h0);
        set_rsp(bus.dc_req_vld, bus.dc_req_tag);
        tick();
        @(negedge clk);
        set_rsp(1'b0, 2'd0);
        tick();

        // SDQ pressure: store granted every cycle until the table fills
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.sdq_almost_full = 1'b1;
            set_ld(1'b1, 3'd1, 32'h4000);
            set_st(1'b1, 3'(7 - i), 32'h5000 + 32'(i * 4), 32'h5A5A_0000 + 32'(i), 4'hC);
            #1;
            chk("af_st_rdy", bus.st_req_rdy, 32'd1);
            chk("af_ld_rdy", bus.ld_req_rdy, 32'd0);
            push_req(1'b1, 32'h5000 + 32'(i * 4), 32'h5A5A_0000 + 32'(i), 4'hC, 2'(i));
            tick();
            check_req("af_req");
        end
        @(negedge clk);
        bus.sdq_almost_full = 1'b0;
        set_st(1'b0, 3'd0, 32'h0, 32'h0, 4'h0);
        set_ld(1'b1, 3'd5, 32'h500);
        #1;
        chk("full_ld_rdy", bus.ld_req_rdy, 32'd0);
        chk("full_st_rdy", bus.st_req_rdy, 32'd0);
        tick();
        chk("full_no_req", bus.dc_req_vld, 32'd0);

        // Free tag 2: not reusable in the freeing cycle, reissued the next
        @(negedge clk);
        set_rsp(1'b1, 2'd2);
        #1;
        chk("free_same_cyc_rdy", bus.ld_req_rdy, 32'd0);
        push_done(1'b1, 3'd5);
        tick();
        check_done("free_done");
        @(negedge clk);
        set_rsp(1'b0, 2'd0);
        #1;
        chk("free_next_cyc_rdy", bus.ld_req_rdy, 32'd1);
        push_req(1'b0, 32'h500, 32'h0, 4'hF, 2'd2);
        tick();
        check_req("reissue_req");
        check_no_done("free_pulse_end");

        // Out-of-order responses: done index follows the responding tag
        rtag = '{0, 3, 1, 2};
        @(negedge clk);
        set_ld(1'b0, 3'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_rsp(1'b1, 2'(rtag[k]));
            if (rtag[k] == 2) push_done(1'b0, 3'd5);
            else              push_done(1'b1, 3'(7 - rtag[k]));
            tick();
            check_done("ooo_done");
        end
        @(negedge clk);
        set_rsp(1'b0, 2'd0);
        tick();

        // Flush: loads 0,1 in flight, store 2, load 3 granted during flush
        @(negedge clk);
        set_ld(1'b1, 3'd1, 32'h600);
        #1;
        chk("fl_ld0_rdy", bus.ld_req_rdy, 32'd1);
        push_req(1'b0, 32'h600, 32'h0, 4'hF, 2'd0);
        tick();
        check_req("fl_ld0_req");
        @(negedge clk);
        set_ld(1'b1, 3'd2, 32'h604);
        #1;
        push_req(1'b0, 32'h604, 32'h0, 4'hF, 2'd1);
        tick();
        check_req("fl_ld1_req");
        @(negedge clk);
        set_ld(1'b0, 3'd0, 32'h0);
        set_st(1'b1, 3'd6, 32'h700, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("fl_st_rdy", bus.st_req_rdy, 32'd1);
        push_req(1'b1, 32'h700, 32'hDEAD_BEEF, 4'hF, 2'd2);
        tick();
        check_req("fl_st_req");
        @(negedge clk);
        set_st(1'b0, 3'd0, 32'h0, 32'h0, 4'h0);
        set_ld(1'b1, 3'd4, 32'h608);
        bus.flush = 1'b1;
        #1;
        chk("fl_cyc_ld_rdy", bus.ld_req_rdy, 32'd1);
        push_req(1'b0, 32'h608, 32'h0, 4'hF, 2'd3);
        tick();
        check_req("fl_ld3_req");
        @(negedge clk);
        bus.flush = 1'b0;
        set_ld(1'b0, 3'd0, 32'h0);
        set_rsp(1'b1, 2'd0);
        tick();
        check_no_done("fl_rsp0");
        @(negedge clk);
        set_rsp(1'b1, 2'd1);
        tick();
        check_no_done("fl_rsp1");
        @(negedge clk);
        set_rsp(1'b1, 2'd2);
        push_done(1'b1, 3'd6);
        tick();
        check_done("fl_rsp2_store");
        @(negedge clk);
        set_rsp(1'b1, 2'd3);
        tick();
        check_no_done("fl_rsp3");
        @(negedge clk);
        set_rsp(1'b0, 2'd0);
        tick();

        // Request held while D-cache stalls, then reset mid-transaction
        @(negedge clk);
        bus.dc_req_rdy = 1'b0;
        set_ld(1'b1, 3'd2, 32'h800);
        #1;
        chk("hold_ld_rdy", bus.ld_req_rdy, 32'd1);
        push_req(1'b0, 32'h800, 32'h0, 4'hF, 2'd0);
        tick();
        check_req("hold_req");
        @(negedge clk);
        set_ld(1'b1, 3'd3, 32'h804);
        #1;
        chk("stall_ld_rdy", bus.ld_req_rdy, 32'd0);
        tick();
        chk("hold_vld", bus.dc_req_vld, 32'd1);
        chk("hold_addr", bus.dc_req_addr, 32'h800);
        @(negedge clk);
        set_ld(1'b0, 3'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dc_vld", bus.dc_req_vld, 32'd0);
        chk("mid_rst_addr", bus.dc_req_addr, 32'h0);
        check_no_done("mid_rst");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        bus.dc_req_rdy = 1'b1;
        @(negedge clk);
        set_rsp(1'b1, 2'd0);
        tick();
        check_no_done("late_rsp");
        @(negedge clk);
        set_rsp(1'b0, 2'd0);
        set_ld(1'b1, 3'd6, 32'h900);
        #1;
        chk("post_rst_ld_rdy", bus.ld_req_rdy, 32'd1);
        push_req(1'b0, 32'h900, 32'h0, 4'hF, 2'd0);
        tick();
        check_req("post_rst_req");
        @(negedge clk);
        set_ld(1'b0, 3'd0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
